mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-002 Parameter TIMEOUT, default 16: max cycles a grant waits for memReady before error completion.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 iReq  input  1  instruction-fetch request, held until iAck.
REQ-006 iAddr  input  32  fetch address.
REQ-007 iAck  output  1  one-cycle fetch completion pulse.
REQ-008 iRdata  output  32  fetched word, valid with iAck.
REQ-009 iErr  output  1  fetch timed out, valid with iAck.
REQ-010 dReq  input  1  data request, held until dAck.
REQ-011 dWe  input  1  1 = store, 0 = load.
REQ-012 dAddr  input  32  data address.
REQ-013 dWdata  input  32  store data.
REQ-014 dByteEn  input  4  store byte lanes.
REQ-015 dAck  output  1  one-cycle data completion pulse.
REQ-016 dRdata  output  32  load data, valid with dAck.
REQ-017 dErr  output  1  data access timed out, valid with dAck.
REQ-018 memValid  output  1  memory request active.
REQ-019 memWe  output  1  memory write strobe.
REQ-020 memAddr  output  32  memory address.
REQ-021 memWdata  output  32  memory write data.
REQ-022 memByteEn  output  4  memory byte lanes.
REQ-023 memRdata  input  32  memory read data, valid with memReady.
REQ-024 memReady  input  1  memory completes the current request.

Function
REQ-025 The block SHALL implement states IDLE, GRANT_I, GRANT_D; all outputs are registered.
REQ-026 In IDLE, only iReq SHALL go to GRANT_I; only dReq SHALL go to GRANT_D; neither SHALL stay in IDLE.
REQ-027 When iReq and dReq are both high in IDLE, the grant SHALL go to the requester not granted last (round-robin on lastGrant).
REQ-028 On entering a GRANT state, the block SHALL latch the winner's address, write data, we and byteEn; for GRANT_I, memWe=0 and memByteEn=4'b1111.
REQ-029 memValid SHALL be 1 for every cycle in a GRANT state, with mem* fields stable, and 0 in IDLE.
REQ-030 In a GRANT state with memReady=1, the block SHALL pulse the winner's ack next cycle with err=0, return to IDLE and set lastGrant to the winner.
REQ-031 Load and fetch completion SHALL load memRdata into iRdata/dRdata; store completion SHALL leave dRdata unchanged; rdata SHALL hold until the next completion on that port.
REQ-032 Minimum latency: request sampled in IDLE at cycle N, memValid from N+1, memReady at N+1, ack at N+2.
REQ-033 A wait counter SHALL clear on grant entry and increment each GRANT cycle without memReady; at TIMEOUT it SHALL complete with ack=1, err=1, rdata=0, and return to IDLE.
REQ-034 When memReady and timeout coincide, memReady SHALL win (normal completion, err=0).
REQ-035 In the ack cycle (state IDLE), the acked requester's req SHALL be masked; the other pending requester SHALL be granted that cycle.
REQ-036 Requests from the non-granted port during a grant SHALL be held pending, never dropped; at most one ack SHALL be high per cycle.
REQ-037 memReady in IDLE SHALL be ignored.

Reset
REQ-038 With rst=1 at a clock edge: state=IDLE, lastGrant=GRANT_D (fetch wins first tie), counter=0, all ack/err/mem* outputs 0, rdata outputs 0.
REQ-039 Reset during a GRANT SHALL abort with no ack; memReady arriving afterwards SHALL be ignored.

Verification
REQ-040 iReq alone, iAddr=0x100, memReady 1 cycle after memValid, memRdata=0xDEADBEEF -> memWe=0, memByteEn=1111, iAck one cycle, iRdata=0xDEADBEEF.
REQ-041 iReq and dReq together after reset -> fetch granted first, then data granted in iAck cycle; next simultaneous pair -> order alternates.
REQ-042 dReq store, dAddr=0x2000, dWdata=0x12345678, dByteEn=0011 -> mem fields match, memWe=1, dAck, dRdata unchanged.
REQ-043 Grant with memReady held 0 -> ack with err=1, rdata=0 exactly TIMEOUT cycles after grant entry; memReady on that cycle -> err=0.
REQ-044 rst pulsed mid-GRANT_D, then memReady=1 -> no dAck, memValid=0, next tie grants fetch.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction fetch and data ports share one memory
// port, with round-robin tie-breaking and a per-grant timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic        iAck,
  output logic [31:0] iRdata,
  output logic        iErr,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [3:0]  dByteEn,
  output logic        dAck,
  output logic [31:0] dRdata,
  output logic        dErr,
  output logic        memValid,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memByteEn,
  input  logic [31:0] memRdata,
  input  logic        memReady
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t         state;
  state_t         lastGrant;
  logic [CntW-1:0] waitCnt;

  logic iReqEff;
  logic dReqEff;
  logic pickI;
  logic pickD;
  logic timeoutHit;
  logic doneNow;

  // A requester still holds req during its own ack cycle, so mask it there.
  assign iReqEff    = iReq & ~iAck;
  assign dReqEff    = dReq & ~dAck;
  assign pickI      = iReqEff & (~dReqEff | (lastGrant == GRANT_D));
  assign pickD      = dReqEff & ~pickI;
  assign timeoutHit = (waitCnt == CntW'(TIMEOUT - 1));
  assign doneNow    = memReady | timeoutHit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= GRANT_D;
      waitCnt   <= '0;
      iAck      <= 1'b0;
      iErr      <= 1'b0;
      iRdata    <= '0;
      dAck      <= 1'b0;
      dErr      <= 1'b0;
      dRdata    <= '0;
      memValid  <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      memByteEn <= '0;
    end else begin
      iAck <= 1'b0;
      dAck <= 1'b0;
      iErr <= 1'b0;
      dErr <= 1'b0;
      unique case (state)
        IDLE: begin
          waitCnt <= '0;
          if (pickI) begin
            state     <= GRANT_I;
            memValid  <= 1'b1;
            memWe     <= 1'b0;
            memAddr   <= iAddr;
            memWdata  <= '0;
            memByteEn <= 4'b1111;
          end else if (pickD) begin
            state     <= GRANT_D;
            memValid  <= 1'b1;
            memWe     <= dWe;
            memAddr   <= dAddr;
            memWdata  <= dWdata;
            memByteEn <= dByteEn;
          end
        end
        GRANT_I, GRANT_D: begin
          if (doneNow) begin
            // memReady has priority over a coincident timeout.
            state     <= IDLE;
            memValid  <= 1'b0;
            memWe     <= 1'b0;
            waitCnt   <= '0;
            lastGrant <= state;
            if (state == GRANT_I) begin
              iAck   <= 1'b1;
              iErr   <= ~memReady;
              iRdata <= memReady ? memRdata : 32'h0;
            end else begin
              dAck <= 1'b1;
              dErr <= ~memReady;
              if (!memReady) begin
                dRdata <= 32'h0;
              end else if (!memWe) begin
                dRdata <= memRdata;
              end
            end
          end else begin
            waitCnt <= waitCnt + CntW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          memValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions, tie and
// reset sequences, with a scoreboard queue checked by a memory-side monitor.
module tb_mem_arbiter;

  localparam int unsigned TO = 16;

  typedef struct {
    bit          port;      // 0 = fetch, 1 = data
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;     // word the memory model returns
    int          delay;     // grant cycles before memReady, -1 = never
    bit          expErr;
    logic [31:0] expRdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iReq = 1'b0;
  logic [31:0] iAddr = '0;
  logic        iAck;
  logic [31:0] iRdata;
  logic        iErr;
  logic        dReq = 1'b0;
  logic        dWe = 1'b0;
  logic [31:0] dAddr = '0;
  logic [31:0] dWdata = '0;
  logic [3:0]  dByteEn = '0;
  logic        dAck;
  logic [31:0] dRdata;
  logic        dErr;
  logic        memValid;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memByteEn;
  logic [31:0] memRdata = '0;
  logic        memReady = 1'b0;

  int nCompared = 0;
  int nMismatch = 0;

  txn_t q[$];
  txn_t cur;
  bit   active = 1'b0;
  int   lat = 0;
  bit   prevValid = 1'b0;
  logic [31:0] prevAddr;
  logic [31:0] prevWdata;
  logic [3:0]  prevBe;
  logic        prevWe;
  bit   forceReady = 1'b0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRdata(iRdata), .iErr(iErr),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dByteEn(dByteEn),
    .dAck(dAck), .dRdata(dRdata), .dErr(dErr),
    .memValid(memValid), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memByteEn(memByteEn), .memRdata(memRdata), .memReady(memReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failNote(input string name);
    nCompared++;
    nMismatch++;
    $display("FAIL %s", name);
  endtask

  // Memory model and scoreboard checker, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      active    = 1'b0;
      prevValid = 1'b0;
      memReady  = forceReady;
    end else begin
      if (active) lat++;
      if (iAck && dAck) failNote("two acks in one cycle");
      if (iAck || dAck) begin
        if (!active) begin
          failNote("unexpected ack");
        end else begin
          check("ack port", 32'(dAck), 32'(cur.port));
          check("ack err", 32'(cur.port ? dErr : iErr), 32'(cur.expErr));
          check("ack rdata", cur.port ? dRdata : iRdata, cur.expRdata);
          check("ack latency", 32'(lat), cur.expErr ? 32'(TO) : 32'(cur.delay + 1));
          active = 1'b0;
        end
      end
      if (memValid && !prevValid) begin
        if (q.size() == 0) begin
          failNote("unexpected grant");
        end else begin
          cur    = q.pop_front();
          active = 1'b1;
          lat    = 0;
          check("memAddr", memAddr, cur.addr);
          check("memWe", 32'(memWe), cur.port ? 32'(cur.we) : 32'h0);
          check("memByteEn", 32'(memByteEn), cur.port ? 32'(cur.be) : 32'hF);
          if (cur.port && cur.we) check("memWdata", memWdata, cur.wdata);
        end
      end else if (memValid) begin
        check("memAddr stable", memAddr, prevAddr);
        check("mem ctl stable", {23'h0, memWe, memByteEn, memWdata[3:0]},
              {23'h0, prevWe, prevBe, prevWdata[3:0]});
      end else if (active && !(iAck || dAck)) begin
        failNote("memValid dropped during grant");
        active = 1'b0;
      end
      memReady  = (active && memValid && lat == cur.delay) || forceReady;
      memRdata  = cur.rdata;
      prevValid = memValid;
      prevAddr  = memAddr;
      prevWdata = memWdata;
      prevBe    = memByteEn;
      prevWe    = memWe;
    end
  end

  task automatic setFetch(input txn_t t);
    iAddr = t.addr;
    iReq  = 1'b1;
  endtask

  task automatic setData(input txn_t t);
    dWe     = t.we;
    dAddr   = t.addr;
    dWdata  = t.wdata;
    dByteEn = t.be;
    dReq    = 1'b1;
  endtask

  // Requesters hold req through their ack cycle and drop it one cycle later.
  task automatic serviceReqs(input int budget);
    bit dropI = 1'b0;
    bit dropD = 1'b0;
    int n = 0;
    while ((iReq || dReq) && n < budget) begin
      @(negedge clk);
      n++;
      if (dropI) begin iReq = 1'b0; dropI = 1'b0; end
      if (dropD) begin dReq = 1'b0; dropD = 1'b0; end
      if (iAck) dropI = 1'b1;
      if (dAck) dropD = 1'b1;
    end
    if (iReq || dReq) begin
      failNote("request never acknowledged");
      iReq = 1'b0;
      dReq = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic runPair(input txn_t ti, input txn_t td, input bit dataFirst);
    if (dataFirst) begin q.push_back(td); q.push_back(ti); end
    else begin q.push_back(ti); q.push_back(td); end
    setFetch(ti);
    setData(td);
    serviceReqs(2 * (TO + 10));
  endtask

  txn_t vecs[9];
  txn_t ti;
  txn_t td;
  bit   sawValid;

  initial begin
    //          port we addr          wdata         be       rdata         dly expErr expRdata
    vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        4'hF,    32'hDEADBEEF, 0,  1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h2000, 32'h12345678, 4'b0011, 32'h99999999, 0,  1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h2004, 32'h0,        4'hF,    32'hCAFEF00D, 2,  1'b0, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b1, 32'h2008, 32'hAAAA5555, 4'b1100, 32'h77777777, 1,  1'b0, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b0, 32'h104,  32'h0,        4'hF,    32'h01234567, 15, 1'b0, 32'h01234567};
    vecs[5] = '{1'b0, 1'b0, 32'h108,  32'h0,        4'hF,    32'hFFFFFFFF, -1, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 32'h200C, 32'h13572468, 4'hF,    32'h0,        -1, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h2010, 32'h0,        4'hF,    32'h0BADF00D, 16, 1'b1, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'h10C,  32'h0,        4'hF,    32'h5A5A5A5A, 3,  1'b0, 32'h5A5A5A5A};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset acks", {30'h0, iAck, dAck}, 32'h0);
    check("reset errs", {30'h0, iErr, dErr}, 32'h0);
    check("reset memValid/We/Be", {26'h0, memValid, memWe, memByteEn}, 32'h0);
    check("reset memAddr", memAddr, 32'h0);
    check("reset iRdata", iRdata, 32'h0);
    check("reset dRdata", dRdata, 32'h0);

    // First tie after reset: fetch wins, data granted in the iAck cycle.
    ti = '{1'b0, 1'b0, 32'h300, 32'h0, 4'hF, 32'h11111111, 1, 1'b0, 32'h11111111};
    td = '{1'b1, 1'b1, 32'h400, 32'h22222222, 4'hF, 32'h0, 0, 1'b0, 32'h0};
    runPair(ti, td, 1'b0);

    foreach (vecs[k]) begin
      q.push_back(vecs[k]);
      if (vecs[k].port) setData(vecs[k]);
      else setFetch(vecs[k]);
      serviceReqs(TO + 10);
    end

    // Fetch was granted last, so this tie goes to data first.
    ti = '{1'b0, 1'b0, 32'h600, 32'h0, 4'hF, 32'h44444444, 2, 1'b0, 32'h44444444};
    td = '{1'b1, 1'b0, 32'h500, 32'h0, 4'h5, 32'h33333333, 0, 1'b0, 32'h33333333};
    runPair(ti, td, 1'b1);

    // Reset in the middle of a data grant, then a stray memReady.
    td = '{1'b1, 1'b0, 32'h700, 32'h0, 4'hF, 32'hEEEEEEEE, -1, 1'b0, 32'hEEEEEEEE};
    q.push_back(td);
    setData(td);
    sawValid = 1'b0;
    for (int n = 0; n < 5 && !sawValid; n++) begin
      @(negedge clk);
      sawValid = memValid;
    end
    check("grant before reset", 32'(sawValid), 32'h1);
    @(negedge clk);
    rst  = 1'b1;
    dReq = 1'b0;
    @(negedge clk);
    check("memValid in reset", 32'(memValid), 32'h0);
    check("dAck in reset", 32'(dAck), 32'h0);
    check("iRdata cleared", iRdata, 32'h0);
    check("dRdata cleared", dRdata, 32'h0);
    @(negedge clk);
    rst        = 1'b0;
    forceReady = 1'b1;
    @(negedge clk);
    check("memValid after stray ready", 32'(memValid), 32'h0);
    @(negedge clk);
    forceReady = 1'b0;
    @(negedge clk);
    check("no ack after abort", {30'h0, iAck, dAck}, 32'h0);
    check("memValid idle", 32'(memValid), 32'h0);

    // Reset restores fetch priority on the next tie.
    ti = '{1'b0, 1'b0, 32'h800, 32'h0, 4'hF, 32'h55555555, 0, 1'b0, 32'h55555555};
    td = '{1'b1, 1'b0, 32'h900, 32'h0, 4'hF, 32'h66666666, 0, 1'b0, 32'h66666666};
    runPair(ti, td, 1'b0);

    check("scoreboard drained", 32'(q.size()), 32'h0);
    check("no grant outstanding", 32'(active), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
